// File: rtl/wave_period_meter.sv
// Square-wave period and high-time meter. A synchronised input feeds a two-state
// measurement FSM that reports cycle counts between accepted rising edges.
module wave_period_meter #(
   parameter int unsigned MIN_PERIOD = 4,
   parameter logic [31:0] MAX_PERIOD = 32'd50_000_000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   input  logic        i_wave_in,
   output logic [31:0] o_period,
   output logic [31:0] o_high_time,
   output logic        o_valid,
   output logic        o_timeout
);

   typedef enum logic {StIdle, StMeasure} state_t;

   state_t      r_state;
   logic        r_sync1;
   logic        r_wave_s;
   logic        r_wave_d;
   logic [31:0] r_cnt;
   logic [31:0] r_hcnt;
   logic [31:0] r_period;
   logic [31:0] r_high_time;
   logic        r_valid;
   logic        r_timeout;

   logic        w_rise;
   logic        w_accept;
   logic        w_cnt_max;
   logic [31:0] w_cnt_next;
   logic [31:0] w_hcnt_next;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1  <= 1'b0;
         r_wave_s <= 1'b0;
         r_wave_d <= 1'b0;
      end else begin
         r_sync1  <= i_wave_in;
         r_wave_s <= r_sync1;
         r_wave_d <= r_wave_s;
      end
   end

   assign w_rise     = r_wave_s & ~r_wave_d;
   assign w_accept   = w_rise && (r_cnt >= MIN_PERIOD);
   assign w_cnt_max  = (r_cnt == MAX_PERIOD);
   assign w_cnt_next = w_cnt_max ? r_cnt : r_cnt + 32'd1;
   assign w_hcnt_next = (r_wave_s && (r_hcnt != MAX_PERIOD)) ? r_hcnt + 32'd1 : r_hcnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_cnt       <= 32'd0;
         r_hcnt      <= 32'd0;
         r_period    <= 32'd0;
         r_high_time <= 32'd0;
         r_valid     <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (!i_en) begin
            r_state <= StIdle;
            r_cnt   <= 32'd0;
            r_hcnt  <= 32'd0;
         end else begin
            unique case (r_state)
               StIdle: begin
                  // First edge only arms the counters; no result yet.
                  if (w_rise) begin
                     r_state <= StMeasure;
                     r_cnt   <= 32'd1;
                     r_hcnt  <= 32'd1;
                  end
               end
               StMeasure: begin
                  if (w_accept) begin
                     r_period    <= r_cnt;
                     r_high_time <= r_hcnt;
                     r_valid     <= 1'b1;
                     r_timeout   <= 1'b0;
                     r_cnt       <= 32'd1;
                     r_hcnt      <= 32'd1;
                  end else if (w_cnt_max) begin
                     r_timeout   <= 1'b1;
                     r_period    <= 32'd0;
                     r_high_time <= 32'd0;
                     r_state     <= StIdle;
                     r_cnt       <= 32'd0;
                     r_hcnt      <= 32'd0;
                  end else begin
                     r_cnt  <= w_cnt_next;
                     r_hcnt <= w_hcnt_next;
                  end
               end
            endcase
         end
      end
   end

   assign o_period    = r_period;
   assign o_high_time = r_high_time;
   assign o_valid     = r_valid;
   assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_wave_period_meter.sv
// Bench for wave_period_meter: directed scenarios plus random waves, compared every
// cycle against an edge-time reference model built from the sampled input history.
module tb_wave_period_meter;

   localparam int MIN_P = 4;
   localparam int MAX_P = 200;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        wave_in = 1'b0;
   logic [31:0] period;
   logic [31:0] high_time;
   logic        valid;
   logic        timeout;

   int n_tests = 0;
   int n_fail = 0;

   wave_period_meter #(
      .MIN_PERIOD(MIN_P),
      .MAX_PERIOD(32'd200)
   ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_en        (en),
      .i_wave_in   (wave_in),
      .o_period    (period),
      .o_high_time (high_time),
      .o_valid     (valid),
      .o_timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   // Reference model: input samples since reset, rising edges found in that history,
   // results derived from distances between accepted edge times.
   bit          samp[$];
   bit          m_meas;
   int          m_last;
   logic        e_valid;
   logic        e_timeout;
   logic [31:0] e_period;
   logic [31:0] e_high;
   int          dut_valids = 0;
   logic [31:0] dut_last_period = 0;

   always begin
      int  j;
      int  k;
      bit  rise;
      int  h;
      @(posedge clk);
      if (rst) begin
         samp.delete();
         m_meas    = 1'b0;
         m_last    = 0;
         e_valid   = 1'b0;
         e_timeout = 1'b0;
         e_period  = 0;
         e_high    = 0;
      end else begin
         samp.push_back(wave_in);
         j = samp.size() - 1;
         // Input sampled at edge k is seen by the result logic at edge k+2.
         k = j - 2;
         rise = (k >= 0) && samp[k] && (k == 0 || !samp[k-1]);
         e_valid = 1'b0;
         if (!en) begin
            m_meas = 1'b0;
         end else if (!m_meas) begin
            if (rise) begin
               m_meas = 1'b1;
               m_last = k;
            end
         end else if (rise && (k - m_last) >= MIN_P) begin
            h = 0;
            for (int i = m_last; i < k; i++) h += int'(samp[i]);
            e_valid   = 1'b1;
            e_period  = k - m_last;
            e_high    = h;
            e_timeout = 1'b0;
            m_last    = k;
         end else if ((k - m_last) == MAX_P) begin
            e_timeout = 1'b1;
            e_period  = 0;
            e_high    = 0;
            m_meas    = 1'b0;
         end
         #1;
         if (!rst) begin
            check("valid", 32'(valid), 32'(e_valid));
            check("timeout", 32'(timeout), 32'(e_timeout));
            check("period", period, e_period);
            check("high_time", high_time, e_high);
            if (valid) begin
               dut_valids++;
               dut_last_period = period;
            end
         end
      end
   end

   // goff < 0 means no glitch pulse.
   task automatic drive_wave(input int per, input int high, input int goff, input int count);
      for (int p = 0; p < count; p++) begin
         for (int c = 0; c < per; c++) begin
            @(negedge clk);
            wave_in = (c < high) || (c == goff);
         end
      end
   endtask

   task automatic drive_low(input int n);
      repeat (n) begin
         @(negedge clk);
         wave_in = 1'b0;
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_period"}, period, 32'd0);
      check({tag, "_high"}, high_time, 32'd0);
      check({tag, "_valid"}, 32'(valid), 32'd0);
      check({tag, "_timeout"}, 32'(timeout), 32'd0);
   endtask

   initial begin
      int base;
      int per;
      int hi;
      int sel;
      int n;
      repeat (2) @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;

      // Steady 100/50 wave, five periods: four results.
      base = dut_valids;
      drive_wave(100, 50, -1, 5);
      check("steady_nvalid", dut_valids - base, 32'd4);
      check("steady_period", period, 32'd100);

      // Duty and frequency change.
      drive_wave(40, 10, -1, 3);
      check("duty1_period", period, 32'd40);
      check("duty1_high", high_time, 32'd10);
      drive_wave(64, 48, -1, 3);
      check("duty2_period", period, 32'd64);
      check("duty2_high", high_time, 32'd48);
      check("duty_timeout", 32'(timeout), 32'd0);

      // Glitch rejected near the rise, accepted far from it.
      drive_wave(100, 1, 2, 3);
      check("glitch_near", period, 32'd100);
      drive_wave(100, 50, 60, 2);
      drive_wave(100, 50, -1, 1);

      // Timeout then recovery, plus an edge exactly at the limit.
      drive_wave(100, 50, -1, 3);
      drive_low(250);
      check("to_flag", 32'(timeout), 32'd1);
      check("to_period", period, 32'd0);
      drive_wave(100, 50, -1, 2);
      drive_wave(200, 50, -1, 1);
      drive_wave(100, 50, -1, 1);
      check("limit_period", dut_last_period, 32'd200);
      check("limit_timeout", 32'(timeout), 32'd0);

      // Enable drop mid-measurement.
      fork
         drive_wave(80, 40, -1, 5);
         begin
            repeat (100) @(negedge clk);
            en = 1'b0;
            repeat (30) @(negedge clk);
            check("en_hold", period, 32'd80);
            en = 1'b1;
         end
      join
      check("en_resume", period, 32'd80);

      // Asynchronous reset mid-period.
      fork
         drive_wave(80, 40, -1, 3);
         begin
            repeat (130) @(negedge clk);
            #2 rst = 1'b1;
            #1 check_zero_outputs("async_rst");
            @(negedge clk);
            rst = 1'b0;
         end
      join

      // Randomised segments.
      for (int it = 0; it < 40; it++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 5) begin
            per = $urandom_range(2, 150);
            hi = $urandom_range(1, per - 1);
            drive_wave(per, hi, -1, $urandom_range(1, 4));
         end else if (sel == 6) begin
            per = $urandom_range(10, 150);
            hi = $urandom_range(1, per / 2);
            drive_wave(per, hi, $urandom_range(hi + 1, per - 1), $urandom_range(1, 3));
         end else if (sel == 7) begin
            drive_low($urandom_range(150, 260));
         end else if (sel == 8) begin
            n = $urandom_range(1, 40);
            fork
               drive_wave(60, 25, -1, 3);
               begin
                  repeat ($urandom_range(1, 100)) @(negedge clk);
                  en = 1'b0;
                  repeat (n) @(negedge clk);
                  en = 1'b1;
               end
            join
         end else begin
            repeat (50) begin
               @(negedge clk);
               wave_in = 1'($urandom_range(0, 1));
            end
         end
      end
      drive_low(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wave_period_meter.md
# wave_period_meter

Measures the period and high time of an incoming square wave in `clk` cycles, for example a tone from the melody path or an external pitch source. It is the receiving end of the tone generator: the generator turns a period word into a wave, and this block turns a wave back into a period word. Results feed comparison and scoring logic downstream. A one-cycle `valid` pulse accompanies each new result. A timeout flags loss of signal.

## Interface
- `MIN_PERIOD`, default 4: rising edges arriving fewer than this many cycles after the previous accepted edge are treated as glitches and ignored.
- `MAX_PERIOD`, default 32'd50_000_000: number of cycles without an accepted edge before timeout; must be ≤ 2^32−1 and > `MIN_PERIOD`.
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: measurement enable, synchronous.
- `wave_in` in 1: asynchronous square-wave input.
- `period` out 32: last measured period, in cycles between accepted rising edges.
- `high_time` out 32: high cycles within that period.
- `valid` out 1: one-cycle pulse when `period` and `high_time` update.
- `timeout` out 1: sticky loss-of-signal flag.

## Operation
- **Input synchronizer:** `wave_in` passes through a 2-FF synchronizer to give `wave_s`, then one more flop to give `wave_d`. `rise = wave_s & ~wave_d`.
- **State machine:** two states, IDLE and MEASURE.
- **IDLE:**
  - On `rise`: go to MEASURE, `cnt` ← 1, `hcnt` ← 1.
  - No `valid` on this first edge.
- **MEASURE, every cycle:**
  - `cnt` increments, saturating at `MAX_PERIOD`.
  - `hcnt` increments while `wave_s` = 1, holds while `wave_s` = 0, and saturates the same way.
- **MEASURE, `rise` with `cnt` ≥ `MIN_PERIOD`:**
  - `period` ← `cnt`, `high_time` ← `hcnt`, `valid` ← 1, `timeout` ← 0.
  - `cnt` ← 1, `hcnt` ← 1.
- **MEASURE, `rise` with `cnt` < `MIN_PERIOD`:** ignored. Counting continues, there is no restart and no `valid`.
- **MEASURE, no accepted rise and `cnt` = `MAX_PERIOD`:**
  - `timeout` ← 1, `period` ← 0, `high_time` ← 0.
  - Go to IDLE, clear the counters.
- A `rise` in the same cycle that `cnt` = `MAX_PERIOD` is accepted: `period` = `MAX_PERIOD` and no timeout.
- **Convention:** an ideal input with period P and high time H gives `period` = P and `high_time` = H.
- **`en` = 0:**
  - Go to IDLE, `cnt` and `hcnt` ← 0, `valid` ← 0.
  - `period`, `high_time` and `timeout` hold.
  - The synchronizer keeps running.
  - Re-enabling requires a fresh first edge.
- **Precedence:** `rst` > `en` = 0 > accepted rise > timeout.
- **Reset values:** state IDLE; synchronizer flops, `cnt`, `hcnt`, `period`, `high_time`, `valid` and `timeout` all 0.
- **Reset mid-measurement:** abandons the measurement immediately, with no `valid`.

## Timing
- **Edge-to-valid latency:** if `wave_in` is first sampled high at clock edge k, then:
  - `wave_s` = 1 after edge k+1;
  - `rise` is true during the cycle after edge k+1;
  - `valid`, `period` and `high_time` update at edge k+2.
- **`valid`:** high for exactly one cycle. Outputs are registered and stable between pulses.
- **`timeout`:** set at the edge where `cnt` reaches `MAX_PERIOD` with no accepted rise, i.e. `MAX_PERIOD` cycles after the last accepted edge.
- **Throughput:** at most one result per `MIN_PERIOD` cycles. Back-to-back results are valid with no dead cycles.
- **Jitter:** the synchronizer adds a constant delay, so it cancels in `period`. Input jitter of ±1 cycle shows up as ±1 in `period`.

## Test plan
- **Steady square wave:** reset, `en` = 1, `wave_in` period 100 cycles (50 high, 50 low) for 5 periods → no `valid` on the first edge, then 4 `valid` pulses, each with `period` = 100 and `high_time` = 50. Check that the first `valid` lands 2 edges after `wave_in` is first sampled high on the second rise.
- **Duty and frequency change:** period 40 / high 10, then switch to period 64 / high 48 → the first result after the switch reports the new values exactly (40/10, then 64/48). `timeout` stays 0.
- **Glitch rejection (`MIN_PERIOD` = 4):** period 100 with a 1-cycle high pulse 2 cycles after a rise → the glitch is ignored and `period` = 100. Then take the same wave with the glitch 60 cycles after the rise → the glitch is accepted as an edge and `period` = 60.
- **Timeout (`MAX_PERIOD` = 200):**
  - Three edges 100 cycles apart, then hold `wave_in` low → `timeout` = 1 exactly 200 cycles after the last edge, with `period` = `high_time` = 0 and the state back in IDLE.
  - Next, two edges 100 apart → `valid` with `period` = 100 and `timeout` cleared.
  - Also: an edge exactly 200 cycles after the previous one → `period` = 200 and no timeout.
- **Enable and reset mid-measurement:**
  - With period 80 running, drop `en` for 30 cycles → `valid` stays 0 and `period` holds 80. After re-enable, the first edge gives no `valid`, the second gives `period` = 80.
  - Assert `rst` asynchronously mid-period → all outputs are 0 immediately, without waiting for a clock edge.
